// File: rtl/rv32_mod_bus_arbiter_if.sv
// rv32_mod_bus_arbiter_if: bundles the core's fetch port (instr_*), the core's
// load/store port (data_*) and the shared memory port (mem_*) of the bus arbiter.
interface rv32_mod_bus_arbiter_if;
    // Fetch port
    logic        instr_req;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_addr;
    logic [31:0] instr_data_o;
    // Load/store port
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_data_i;
    logic        data_ack;
    logic        data_err;
    logic [31:0] data_data_o;
    // Shared memory port
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_o;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_data_i;

    // Arbiter view: answers the core's requests and drives the memory port.
    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_wr, data_be, data_addr, data_data_i,
        input  mem_ack, mem_err, mem_data_i,
        output instr_ack, instr_err, instr_data_o,
        output data_ack, data_err, data_data_o,
        output mem_req, mem_wr, mem_be, mem_addr, mem_data_o
    );

    // Environment view: the core issuing requests and the memory answering them.
    modport master (
        output instr_req, instr_addr,
        output data_req, data_wr, data_be, data_addr, data_data_i,
        output mem_ack, mem_err, mem_data_i,
        input  instr_ack, instr_err, instr_data_o,
        input  data_ack, data_err, data_data_o,
        input  mem_req, mem_wr, mem_be, mem_addr, mem_data_o
    );
endinterface

// File: rtl/rv32_mod_bus_arbiter.sv
// rv32_mod_bus_arbiter: merges the core's fetch and load/store ports onto one
// memory handshake port. One master is granted at a time and keeps the grant until
// its transaction completes, errors, times out or is abandoned by the master.
// Optional macro RV32_ARB_RESP_REG_EN registers the slave response and returns it
// one cycle later from a RESP state, breaking the combinational mem->core path.
module rv32_mod_bus_arbiter #(
    parameter bit          DATA_PRIORITY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rv32_mod_bus_arbiter_if.slave bus
);

    localparam bit               TimeoutEn  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

    // Encoding of last_grant_q
    localparam logic GrantInstr = 1'b0;
    localparam logic GrantData  = 1'b1;

`ifdef RV32_ARB_RESP_REG_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2,
        StResp = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } state_e;
`endif

    state_e           state_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef RV32_ARB_RESP_REG_EN
    logic             resp_ack_q;
    logic             resp_err_q;
    logic [31:0]      resp_data_q;
`endif

    logic gnt_req;
    logic mem_done;
    logic timeout_hit;
    logic pick_data;

    // Granted master still requesting; mem_* outputs are gated by this.
    assign gnt_req  = ((state_q == StGntI) && bus.instr_req) ||
                      ((state_q == StGntD) && bus.data_req);
    assign mem_done = bus.mem_ack || bus.mem_err;

    // Timeout fires when the counter reaches the limit with no slave response.
    always_comb begin
        timeout_hit = 1'b0;
        if (TimeoutEn && gnt_req && !mem_done) begin
            timeout_hit = (cnt_q == TimeoutVal);
        end
    end

    // Winner selection for the next grant out of IDLE.
    always_comb begin
        pick_data = 1'b0;
        if (bus.data_req && !bus.instr_req) begin
            pick_data = 1'b1;
        end else if (bus.instr_req && !bus.data_req) begin
            pick_data = 1'b0;
        end else if (DATA_PRIORITY) begin
            pick_data = 1'b1;
        end else begin
            // Round-robin: the master that was not granted last time wins.
            pick_data = (last_grant_q == GrantInstr);
        end
    end

    // FSM: grant selection, completion/abort/timeout handling, timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantData;
            cnt_q        <= '0;
`ifdef RV32_ARB_RESP_REG_EN
            resp_ack_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_req || bus.data_req) begin
                        state_q      <= pick_data ? StGntD : StGntI;
                        last_grant_q <= pick_data ? GrantData : GrantInstr;
                        cnt_q        <= '0;
                    end
                end
                StGntI, StGntD: begin
                    if (mem_done) begin
`ifdef RV32_ARB_RESP_REG_EN
                        state_q     <= StResp;
                        // Error wins over a simultaneous ack.
                        resp_ack_q  <= bus.mem_ack && !bus.mem_err;
                        resp_err_q  <= bus.mem_err;
                        resp_data_q <= bus.mem_data_i;
`else
                        state_q     <= StIdle;
`endif
                    end else if (timeout_hit || !gnt_req) begin
                        state_q <= StIdle;
                    end else if (TimeoutEn) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef RV32_ARB_RESP_REG_EN
                StResp: begin
                    state_q     <= StIdle;
                    resp_ack_q  <= 1'b0;
                    resp_err_q  <= 1'b0;
                    resp_data_q <= '0;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output steering: memory port from the granted master, response to it only.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_be       = 4'h0;
        bus.mem_addr     = '0;
        bus.mem_data_o   = '0;
        bus.instr_ack    = 1'b0;
        bus.instr_err    = 1'b0;
        bus.instr_data_o = '0;
        bus.data_ack     = 1'b0;
        bus.data_err     = 1'b0;
        bus.data_data_o  = '0;
        unique case (state_q)
            StGntI: begin
                if (bus.instr_req) begin
                    bus.mem_req  = !timeout_hit;
                    bus.mem_be   = 4'hF;
                    bus.mem_addr = bus.instr_addr;
                end
`ifdef RV32_ARB_RESP_REG_EN
                bus.instr_err    = timeout_hit;
`else
                bus.instr_ack    = bus.mem_ack && !bus.mem_err;
                bus.instr_err    = bus.mem_err || timeout_hit;
                bus.instr_data_o = bus.mem_data_i;
`endif
            end
            StGntD: begin
                if (bus.data_req) begin
                    bus.mem_req    = !timeout_hit;
                    bus.mem_wr     = bus.data_wr;
                    bus.mem_be     = bus.data_be;
                    bus.mem_addr   = bus.data_addr;
                    bus.mem_data_o = bus.data_data_i;
                end
`ifdef RV32_ARB_RESP_REG_EN
                bus.data_err    = timeout_hit;
`else
                bus.data_ack    = bus.mem_ack && !bus.mem_err;
                bus.data_err    = bus.mem_err || timeout_hit;
                bus.data_data_o = bus.mem_data_i;
`endif
            end
`ifdef RV32_ARB_RESP_REG_EN
            StResp: begin
                if (last_grant_q == GrantData) begin
                    bus.data_ack    = resp_ack_q;
                    bus.data_err    = resp_err_q;
                    bus.data_data_o = resp_data_q;
                end else begin
                    bus.instr_ack    = resp_ack_q;
                    bus.instr_err    = resp_err_q;
                    bus.instr_data_o = resp_data_q;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// tb_rv32_mod_bus_arbiter: self-checking bench. u_dut_a (data priority, timeout 5)
// is checked through a response scoreboard; u_dut_b (round-robin) checks grant order.
module tb_rv32_mod_bus_arbiter;

`ifdef RV32_ARB_RESP_REG_EN
    localparam int RespLat = 1;
`else
    localparam int RespLat = 0;
`endif

    typedef struct {
        bit          is_data;
        bit          err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    resp_t exp_q[$];
    int unsigned slv_lat = 1;
    int slv_mode = 0;  // 0: ack, 1: err, 2: never respond
    bit force_ack = 1'b0;

    rv32_mod_bus_arbiter_if bus_a();
    rv32_mod_bus_arbiter_if bus_b();

    rv32_mod_bus_arbiter #(
        .DATA_PRIORITY (1'b1),
        .TIMEOUT_CYCLES(5),
        .CNT_W         (8)
    ) u_dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a.slave)
    );

    rv32_mod_bus_arbiter #(
        .DATA_PRIORITY (1'b0),
        .TIMEOUT_CYCLES(0),
        .CNT_W         (8)
    ) u_dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b.slave)
    );

    function automatic logic [31:0] slave_rdata(input logic [31:0] addr);
        return addr + 32'hCEAD_BEEF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_data, input bit err, input logic [31:0] data);
        resp_t e;
        e.is_data = is_data;
        e.err     = err;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    // Core-side master: raise req, hold it until ack/err, then drop it.
    task automatic master_xfer(input bit is_data, input bit wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
        bit done = 1'b0;
        @(negedge clk);
        if (is_data) begin
            bus_a.data_req = 1'b1;  bus_a.data_wr = wr;  bus_a.data_be = be;
            bus_a.data_addr = addr; bus_a.data_data_i = wdata;
        end else begin
            bus_a.instr_req = 1'b1; bus_a.instr_addr = addr;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #2;
            done = is_data ? (bus_a.data_ack || bus_a.data_err)
                           : (bus_a.instr_ack || bus_a.instr_err);
        end
        if (!done) check_val(is_data ? "data_resp_wait" : "instr_resp_wait", 0, 1);
        @(negedge clk);
        if (is_data) begin
            bus_a.data_req = 1'b0;  bus_a.data_wr = 1'b0; bus_a.data_be = 4'h0;
            bus_a.data_addr = '0;   bus_a.data_data_i = '0;
        end else begin
            bus_a.instr_req = 1'b0; bus_a.instr_addr = '0;
        end
    endtask

    // Memory slave model for u_dut_a.
    initial begin
        int unsigned slv_wait = 0;
        forever begin
            @(negedge clk);
            #1;
            bus_a.mem_ack = 1'b0; bus_a.mem_err = 1'b0; bus_a.mem_data_i = '0;
            if (force_ack) begin
                bus_a.mem_ack = 1'b1;
                bus_a.mem_data_i = 32'hBAD0_BAD0;
            end else if (bus_a.mem_req) begin
                if (slv_wait >= slv_lat && slv_mode != 2) begin
                    if (slv_mode == 1) bus_a.mem_err = 1'b1;
                    else               bus_a.mem_ack = 1'b1;
                    bus_a.mem_data_i = slave_rdata(bus_a.mem_addr);
                    slv_wait = 0;
                end else begin
                    slv_wait++;
                end
            end else begin
                slv_wait = 0;
            end
        end
    end

    // Response monitor: every ack/err seen on u_dut_a pops one expected entry.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus_a.instr_ack || bus_a.instr_err || bus_a.data_ack || bus_a.data_err) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("resp_port", bus_a.data_ack || bus_a.data_err, e.is_data);
                    if (e.is_data) begin
                        check_val("data_err", bus_a.data_err, e.err);
                        check_val("data_ack", bus_a.data_ack, !e.err);
                        if (!e.err) check_val("data_rdata", bus_a.data_data_o, e.data);
                        check_val("instr_quiet", {bus_a.instr_ack, bus_a.instr_err}, 0);
                        check_val("instr_data_quiet", bus_a.instr_data_o, 0);
                    end else begin
                        check_val("instr_err", bus_a.instr_err, e.err);
                        check_val("instr_ack", bus_a.instr_ack, !e.err);
                        if (!e.err) check_val("instr_rdata", bus_a.instr_data_o, e.data);
                        check_val("data_quiet", {bus_a.data_ack, bus_a.data_err}, 0);
                        check_val("data_data_quiet", bus_a.data_data_o, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cyc;
        int gcnt;
        int err_cyc;
        int unsigned wait_b;
        logic [6:0] pat;
        logic [6:0] exp_pat;
        bit got_q[$];
        bit rr_exp_q[$];

        bus_a.instr_req = 0; bus_a.instr_addr = '0; bus_a.data_req = 0; bus_a.data_wr = 0;
        bus_a.data_be = '0; bus_a.data_addr = '0; bus_a.data_data_i = '0;
        bus_a.mem_ack = 0; bus_a.mem_err = 0; bus_a.mem_data_i = '0;
        bus_b.instr_req = 0; bus_b.instr_addr = '0; bus_b.data_req = 0; bus_b.data_wr = 0;
        bus_b.data_be = '0; bus_b.data_addr = '0; bus_b.data_data_i = '0;
        bus_b.mem_ack = 0; bus_b.mem_err = 0; bus_b.mem_data_i = '0;

        // Reset state: every output low.
        #3;
        check_val("rst_mem_req", bus_a.mem_req, 0);
        check_val("rst_mem_addr", bus_a.mem_addr, 0);
        check_val("rst_mem_be", bus_a.mem_be, 0);
        check_val("rst_acks", {bus_a.instr_ack, bus_a.instr_err, bus_a.data_ack,
                               bus_a.data_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;

        // Single fetch, slave acks two cycles after mem_req.
        slv_lat = 2; slv_mode = 0;
        push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h1000_0000;
        #2;
        check_val("fetch_req_delay", bus_a.mem_req, 0);
        ack_cyc = -1;
        for (int c = 1; c <= 12 && ack_cyc < 0; c++) begin
            @(negedge clk);
            #2;
            if (c == 1) begin
                check_val("fetch_mem_req", bus_a.mem_req, 1);
                check_val("fetch_mem_addr", bus_a.mem_addr, 32'h1000_0000);
                check_val("fetch_mem_wr", bus_a.mem_wr, 0);
                check_val("fetch_mem_be", bus_a.mem_be, 4'hF);
            end
            if (bus_a.instr_ack) ack_cyc = c;
        end
        check_val("fetch_ack_cycle", ack_cyc, 3 + RespLat);
        @(negedge clk);
        bus_a.instr_req = 1'b0; bus_a.instr_addr = '0;
        #2;
        check_val("fetch_ack_one_cycle", bus_a.instr_ack, 0);

        // Simultaneous requests with data priority: data first, then instruction.
        slv_lat = 1;
        push_exp(1'b1, 1'b0, slave_rdata(32'h8000_0004));
        push_exp(1'b0, 1'b0, slave_rdata(32'h1000_0010));
        exp_pat = (RespLat == 0) ? 7'b0110110 : 7'b1100110;
        fork
            master_xfer(1'b1, 1'b1, 4'h3, 32'h8000_0004, 32'h0000_1234);
            master_xfer(1'b0, 1'b0, 4'hF, 32'h1000_0010, 32'h0);
            begin
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    #2;
                    pat[c] = bus_a.mem_req;
                    if (c == 1) begin
                        check_val("prio_wr", bus_a.mem_wr, 1);
                        check_val("prio_be", bus_a.mem_be, 4'h3);
                        check_val("prio_addr", bus_a.mem_addr, 32'h8000_0004);
                        check_val("prio_wdata", bus_a.mem_data_o, 32'h0000_1234);
                    end
                    if (c == 4 + RespLat) check_val("prio_second_addr", bus_a.mem_addr,
                                                    32'h1000_0010);
                end
                // pat[0] is the first cycle; reverse-order constant above matches bit index
                check_val("prio_req_pattern", pat,
                          (RespLat == 0) ? 7'b0110110 : 7'b1100110);
            end
        join
        #2;
        check_val("prio_quiet", {bus_a.instr_ack, bus_a.data_ack}, 0);

        // Load answered with mem_err: one-cycle data_err, no data_ack.
        slv_mode = 1;
        push_exp(1'b1, 1'b1, 32'h0);
        master_xfer(1'b1, 1'b0, 4'hF, 32'h8000_0100, 32'h0);
        #2;
        check_val("err_pulse_end", {bus_a.data_err, bus_a.data_ack}, 0);

        // Fetch timeout: five granted cycles, then a single-cycle instr_err.
        slv_mode = 2;
        push_exp(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h1000_0020;
        gcnt = 0; err_cyc = -1;
        for (int c = 1; c <= 12 && err_cyc < 0; c++) begin
            @(negedge clk);
            #2;
            if (bus_a.instr_err) begin
                err_cyc = c;
                check_val("to_mem_req_low", bus_a.mem_req, 0);
            end else if (bus_a.mem_req) begin
                gcnt++;
            end
        end
        check_val("to_granted_cycles", gcnt, 5);
        check_val("to_err_cycle", err_cyc, 6);
        @(negedge clk);
        bus_a.instr_req = 1'b0; bus_a.instr_addr = '0;
        #2;
        check_val("to_err_one_cycle", {bus_a.instr_err, bus_a.mem_req}, 0);
        // Late ack in IDLE must not reach either master.
        @(negedge clk);
        force_ack = 1'b1;
        #2;
        check_val("late_ack_ignored", {bus_a.instr_ack, bus_a.data_ack}, 0);
        @(negedge clk);
        force_ack = 1'b0;
        #2;

        // Abort: granted master drops req, mem_req falls in the same cycle.
        @(negedge clk);
        bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h1000_0030;
        @(negedge clk);
        #2;
        check_val("abort_granted", bus_a.mem_req, 1);
        @(negedge clk);
        bus_a.instr_req = 1'b0;
        #2;
        check_val("abort_req_drop", bus_a.mem_req, 0);
        @(negedge clk);
        #2;
        check_val("abort_idle", bus_a.mem_req, 0);

        // Reset mid-transaction while the data grant waits for mem_ack.
        @(negedge clk);
        bus_a.data_req = 1'b1; bus_a.data_addr = 32'h8000_0200; bus_a.data_be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2;
        check_val("rst_mid_granted", bus_a.mem_req, 1);
        #1;
        reset = 1'b0;
        #1;
        check_val("rst_mid_mem_req", bus_a.mem_req, 0);
        check_val("rst_mid_mem_addr", bus_a.mem_addr, 0);
        check_val("rst_mid_resp", {bus_a.data_ack, bus_a.data_err, bus_a.mem_be}, 0);
        @(negedge clk);
        bus_a.data_req = 1'b0; bus_a.data_addr = '0; bus_a.data_be = '0;
        slv_mode = 0;
        @(negedge clk);
        reset = 1'b1;
        gcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            if (bus_a.mem_req || bus_a.data_ack || bus_a.instr_ack) gcnt++;
        end
        check_val("rst_no_stale", gcnt, 0);
        push_exp(1'b0, 1'b0, slave_rdata(32'h1000_0040));
        master_xfer(1'b0, 1'b0, 4'hF, 32'h1000_0040, 32'h0);
        #2;

        // Round-robin on u_dut_b: both requests held for four transactions.
        rr_exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus_b.instr_req = 1'b1; bus_b.instr_addr = 32'h1000_0000;
        bus_b.data_req = 1'b1;  bus_b.data_addr = 32'h8000_0000; bus_b.data_be = 4'hF;
        wait_b = 0;
        for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
            @(negedge clk);
            #1;
            bus_b.mem_ack = 1'b0;
            if (bus_b.mem_req) begin
                if (wait_b >= 1) begin
                    bus_b.mem_ack = 1'b1;
                    wait_b = 0;
                end else begin
                    wait_b++;
                end
            end else begin
                wait_b = 0;
            end
            #1;
            if (bus_b.instr_ack) got_q.push_back(1'b0);
            if (bus_b.data_ack)  got_q.push_back(1'b1);
        end
        @(negedge clk);
        bus_b.instr_req = 1'b0; bus_b.data_req = 1'b0; bus_b.mem_ack = 1'b0;
        check_val("rr_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check_val("rr_order", got_q[i], rr_exp_q[i]);
        end

        repeat (3) @(negedge clk);
        check_val("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32_mod_bus_arbiter.md
Name: rv32_mod_bus_arbiter

Overview:
- Two-master to one-slave bus arbiter directly downstream of the rv32imc_ss_handshake core.
- Merges the core's instruction-fetch port (instr_*) and load/store port (data_*) onto one memory handshake port (mem_*), so the core can run on a single-ported RAM or bus.
- Grants one master at a time and holds the grant until that transaction completes.
- Returns ack, err and read data only to the granted master.

Parameters:
- DATA_PRIORITY, 1, tie-break policy: 1 = data port wins simultaneous requests; 0 = round-robin.
- TIMEOUT_CYCLES, 0, number of granted cycles without mem_ack/mem_err before a bus error is forced; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- instr_req  in  1  fetch request from core, held until ack/err
- instr_ack  out  1  fetch complete
- instr_err  out  1  fetch bus error
- instr_addr  in  32  fetch address
- instr_data_o  out  32  fetched word to core
- data_req  in  1  load/store request, held until ack/err
- data_wr  in  1  1 = store
- data_be  in  4  byte enables
- data_addr  in  32  load/store address
- data_data_i  in  32  store data from core
- data_ack  out  1  load/store complete
- data_err  out  1  load/store bus error
- data_data_o  out  32  load data to core
- mem_req  out  1  slave request
- mem_wr  out  1  slave write
- mem_be  out  4  slave byte enables
- mem_addr  out  32  slave address
- mem_data_o  out  32  slave write data
- mem_ack  in  1  slave completion
- mem_err  in  1  slave error
- mem_data_i  in  32  slave read data

Behaviour:
Reset (reset low, asynchronous):
- state = IDLE, last_grant = DATA, timeout counter = 0.
- All outputs are 0.
- A transaction in flight when reset is asserted is abandoned. No ack/err is produced for it after reset is released.

IDLE:
- mem_req = 0.
- On a clock edge with any request present, select a winner and move to GNT_I or GNT_D. mem_req rises one cycle after the request is first seen.
- Only one request present: that master wins.
- Both requests present, DATA_PRIORITY=1: data wins.
- Both requests present, DATA_PRIORITY=0: the master not equal to last_grant wins.
- last_grant is updated when the winner is selected.

GNT_I / GNT_D:
- mem_req/mem_wr/mem_be/mem_addr/mem_data_o are driven combinationally from the granted master, gated by its req.
- Instruction grant: mem_wr = 0, mem_be = 4'hF, mem_data_o = 0.
- mem_ack/mem_err/mem_data_i are forwarded combinationally to the granted master's ack/err/data_o in the same cycle. The non-granted master sees ack = err = 0 and data_o = 0.
- On mem_ack or mem_err: return to IDLE. There is one idle cycle between back-to-back transactions. If mem_ack and mem_err are both high, err is forwarded and ack is suppressed.
- Granted master drops req before completion (abort): mem_req falls in the same cycle and the state returns to IDLE on the next edge.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on grant and increments each granted cycle.
  - When the counter reaches TIMEOUT_CYCLES with no mem_ack/mem_err, the arbiter asserts err to the granted master for exactly one cycle, drives mem_req = 0, and returns to IDLE.
  - mem_ack/mem_err arriving while IDLE is ignored.
- The non-granted master's request is held off; no ack is given until it is granted.

Optional Feature:
- Macro: RV32_ARB_RESP_REG_EN.
- Defined:
  - Adds state RESP.
  - On mem_ack/mem_err the arbiter registers the response (ack, err, data) and moves to RESP. mem_req = 0 in RESP.
  - In RESP the registered ack/err/data are driven to the granted master for exactly one cycle, then the state returns to IDLE.
  - Response latency to the master is +1 cycle; this breaks the combinational mem→core return path.
- Not defined: combinational return path as above; RESP does not exist.

Test Plan:
- Single fetch: instr_req=1, instr_addr=0x10000000; mem_ack=1 with mem_data_i=0xDEADBEEF two cycles after mem_req -> mem_req rises 1 cycle after instr_req, mem_addr=0x10000000, mem_wr=0, mem_be=0xF; instr_ack=1 and instr_data_o=0xDEADBEEF in the mem_ack cycle; data_ack stays 0.
- Simultaneous requests, DATA_PRIORITY=1: instr_req and data_req (store, addr 0x80000004, be 0x3, data 0x1234) both held -> data granted first (mem_wr=1, mem_be=0x3); after its ack, one IDLE cycle, then the instruction grant.
- Round-robin, DATA_PRIORITY=0: both requests held continuously for 4 transactions with mem_ack after 1 cycle each -> grant order I, D, I, D.
- Error and timeout, TIMEOUT_CYCLES=5:
  - data load with mem_err=1 -> data_err pulse for 1 cycle, no data_ack.
  - fetch with mem_ack never asserted -> instr_err for exactly 1 cycle after 5 granted cycles, then mem_req=0.
  - a late mem_ack after the timeout is ignored.
- Reset mid-transaction: reset driven low while GNT_D is waiting for mem_ack -> all outputs 0 immediately, without a clock edge; after release, the state is IDLE and no stale ack is produced.
- RV32_ARB_RESP_REG_EN defined: single fetch as in the first scenario -> instr_ack and data 0xDEADBEEF appear one cycle after mem_ack, for exactly one cycle.
